// File: rtl/cmp_pkg.sv
// cmp_pkg -- shared types and helpers for the cascadable magnitude comparator.
//   cmp_res_t   : packed partial compare result {eq, gt}; LT is encoded as {0,0}.
//   CMP_DEF_WIDTH : default operand width.
//   CMP_EQ      : the "equal so far" result, used to seed leaves and pad the tree.
//   cmp_merge() : combine a more-significant result (hi) with a less-significant one (lo).
package cmp_pkg;

    typedef struct packed {
        logic eq;
        logic gt;
    } cmp_res_t;

    localparam int CMP_DEF_WIDTH = 8;

    localparam cmp_res_t CMP_EQ = 2'b10;

    // The high side decides unless it is still equal, in which case the low side decides.
    function automatic cmp_res_t cmp_merge(input cmp_res_t hi, input cmp_res_t lo);
        cmp_res_t r;
        r.eq = hi.eq & lo.eq;
        r.gt = hi.gt | (hi.eq & lo.gt);
        return r;
    endfunction

endpackage

// File: rtl/cmp_cell.sv
// cmp_cell -- one-bit compare stage.
//   a_i, b_i : operand bits at this position
//   prev_i   : result of all more-significant positions (CMP_EQ for a leaf)
//   next_o   : result including this bit
// A settled GT/LT on prev_i passes through; an EQ prev_i lets this bit decide.
module cmp_cell
    import cmp_pkg::*;
(
    input  logic     a_i,
    input  logic     b_i,
    input  cmp_res_t prev_i,
    output cmp_res_t next_o
);

    cmp_res_t leaf;

    assign leaf.eq = ~(a_i ^ b_i);
    assign leaf.gt = a_i & ~b_i;
    assign next_o  = cmp_merge(prev_i, leaf);

endmodule

// File: rtl/cascade_mag_cmp.sv
// cascade_mag_cmp -- registered unsigned magnitude comparator with cascade inputs.
// Chain several instances to build a wider compare: the MSB-side block's result feeds
// eq_in/gt_in of the next, less-significant block.
//   clk        : clock, all state on the rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : a/b/eq_in/gt_in valid this cycle
//   a, b       : WIDTH-bit unsigned operands
//   eq_in      : more-significant stages equal so far (1 when standalone)
//   gt_in      : more-significant stages already A>B (0 when standalone); wins over eq_in
//   out_valid  : registered result valid (1 cycle after in_valid)
//   eq_out/gt_out/lt_out : one-hot cascaded result, held while in_valid is low
// Build option: define CMP_TREE_EN for a log2(WIDTH)-deep reduction tree; otherwise the
// core is a linear MSB-to-LSB ripple of cmp_cell stages. Both give identical port behaviour.
module cascade_mag_cmp
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             eq_in,
    input  logic             gt_in,
    output logic             out_valid,
    output logic             eq_out,
    output logic             gt_out,
    output logic             lt_out
);

    cmp_res_t cas_res;
    cmp_res_t core_res;

    // Cascade decode: gt_in dominates, otherwise eq_in selects EQ vs LT.
    always_comb begin
        cas_res = 2'b00;
        if (gt_in) begin
            cas_res = 2'b01;
        end else if (eq_in) begin
            cas_res = CMP_EQ;
        end
    end

`ifdef CMP_TREE_EN
    localparam int LVLS = $clog2(WIDTH);
    localparam int P    = 1 << LVLS;

    // Heap-ordered tree: node 0 is the root, children of k are 2k+1 (more significant)
    // and 2k+2. Leaf j holds bit WIDTH-1-j, so unused leaves sit on the LSB side where
    // padding with EQ cannot change the answer.
    cmp_res_t node [2*P-1];

    genvar gi;
    generate
        for (gi = 0; gi < P; gi++) begin : g_leaf
            if (gi < WIDTH) begin : g_bit
                cmp_cell u_leaf (
                    .a_i    (a[WIDTH-1-gi]),
                    .b_i    (b[WIDTH-1-gi]),
                    .prev_i (CMP_EQ),
                    .next_o (node[P-1+gi])
                );
            end else begin : g_pad
                assign node[P-1+gi] = CMP_EQ;
            end
        end
        for (gi = 0; gi < P-1; gi++) begin : g_merge
            assign node[gi] = cmp_merge(node[2*gi+1], node[2*gi+2]);
        end
    endgenerate

    assign core_res = cmp_merge(cas_res, node[0]);
`else
    // chain[WIDTH] is the cascade seed; chain[i] is the result after bit i.
    cmp_res_t chain [WIDTH+1];

    assign chain[WIDTH] = cas_res;

    genvar gi;
    generate
        for (gi = WIDTH-1; gi >= 0; gi--) begin : g_ripple
            cmp_cell u_cell (
                .a_i    (a[gi]),
                .b_i    (b[gi]),
                .prev_i (chain[gi+1]),
                .next_o (chain[gi])
            );
        end
    endgenerate

    assign core_res = chain[0];
`endif

    logic out_valid_q, out_valid_d;
    logic eq_q, eq_d;
    logic gt_q, gt_d;
    logic lt_q, lt_d;

    // Results update only on accepted inputs; otherwise they hold.
    always_comb begin
        out_valid_d = in_valid;
        eq_d        = eq_q;
        gt_d        = gt_q;
        lt_d        = lt_q;
        if (in_valid) begin
            eq_d = core_res.eq;
            gt_d = core_res.gt;
            lt_d = ~core_res.eq & ~core_res.gt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            eq_q        <= 1'b0;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            eq_q        <= eq_d;
            gt_q        <= gt_d;
            lt_q        <= lt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign eq_out    = eq_q;
    assign gt_out    = gt_q;
    assign lt_out    = lt_q;

endmodule

// File: tb/tb_cascade_mag_cmp.sv
// Directed and random checks of cascade_mag_cmp at WIDTH=8.
// Observed/expected values are packed as {out_valid, eq_out, gt_out, lt_out}.
module tb_cascade_mag_cmp;

    localparam int W = 8;

    localparam logic [3:0] R_EQ   = 4'b1100;
    localparam logic [3:0] R_GT   = 4'b1010;
    localparam logic [3:0] R_LT   = 4'b1001;
    localparam logic [3:0] R_ZERO = 4'b0000;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         eq_in;
    logic         gt_in;
    logic         out_valid;
    logic         eq_out;
    logic         gt_out;
    logic         lt_out;

    int total = 0;
    int bad   = 0;

    cascade_mag_cmp #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .eq_in     (eq_in),
        .gt_in     (gt_in),
        .out_valid (out_valid),
        .eq_out    (eq_out),
        .gt_out    (gt_out),
        .lt_out    (lt_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] observed();
        return {out_valid, eq_out, gt_out, lt_out};
    endfunction

    // Reference: behavioural integer compare, returns {eq, gt, lt}.
    function automatic logic [2:0] ref_cmp(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                           input logic req, input logic rgt);
        if (rgt)       return 3'b010;
        if (!req)      return 3'b001;
        if (ra > rb)   return 3'b010;
        if (ra < rb)   return 3'b001;
        return 3'b100;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Present one input for one cycle (called at posedge+1), then compare at next posedge+1.
    task automatic step(input string tag, input logic [W-1:0] sa, input logic [W-1:0] sb,
                        input logic seq, input logic sgt, input logic sv,
                        input logic [3:0] exp);
        a        = sa;
        b        = sb;
        eq_in    = seq;
        gt_in    = sgt;
        in_valid = sv;
        @(posedge clk);
        #1;
        $display("step %s a=%h b=%h eq_in=%b gt_in=%b v=%b -> %b", tag, sa, sb, seq, sgt, sv, observed());
        check(tag, observed(), exp);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         req, rgt, rv;
        logic [2:0]   exp_res;
        logic         exp_ov;

        rst_n    = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        eq_in    = 1'b1;
        gt_in    = 1'b0;

        // Reset state, applied immediately on rst_n falling.
        #2 rst_n = 1'b0;
        #1 check("reset_state", observed(), R_ZERO);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1 check("post_reset_idle", observed(), R_ZERO);

        // T1 equal
        step("t1_eq",      8'h2E, 8'h2E, 1'b1, 1'b0, 1'b1, R_EQ);
        // T2 LSB/MSB walk
        step("t2_lsb_lt",  8'h2E, 8'h2F, 1'b1, 1'b0, 1'b1, R_LT);
        step("t2_eq_a",    8'h2F, 8'h2F, 1'b1, 1'b0, 1'b1, R_EQ);
        step("t2_msb_lt",  8'h2F, 8'hAF, 1'b1, 1'b0, 1'b1, R_LT);
        step("t2_eq_b",    8'hAF, 8'hAF, 1'b1, 1'b0, 1'b1, R_EQ);
        step("t2_gt",      8'hFF, 8'hBF, 1'b1, 1'b0, 1'b1, R_GT);
        // T3 cascade override
        step("t3_gt_in",   8'h00, 8'hFF, 1'b1, 1'b1, 1'b1, R_GT);
        step("t3_lt_in",   8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, R_LT);
        step("t3_gt_only", 8'h01, 8'h80, 1'b0, 1'b1, 1'b1, R_GT);
        // Boundaries
        step("bnd_zero",   8'h00, 8'h00, 1'b1, 1'b0, 1'b1, R_EQ);
        step("bnd_max_gt", 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, R_GT);
        step("bnd_max_lt", 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, R_LT);
        step("bnd_ones_eq",8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, R_EQ);
        // T4 back-to-back then hold
        step("t4_bb0",     8'h01, 8'h02, 1'b1, 1'b0, 1'b1, R_LT);
        step("t4_bb1",     8'h05, 8'h05, 1'b1, 1'b0, 1'b1, R_EQ);
        step("t4_bb2",     8'h80, 8'h7F, 1'b1, 1'b0, 1'b1, R_GT);
        step("t4_bb3",     8'h10, 8'h11, 1'b1, 1'b0, 1'b1, R_LT);
        step("t4_hold0",   8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 4'b0001);
        step("t4_hold1",   8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 4'b0001);
        step("t4_gt_set",  8'h90, 8'h0F, 1'b1, 1'b0, 1'b1, R_GT);
        step("t4_hold2",   8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 4'b0010);

        // T5 reset between edges right after a valid input is presented
        step("t5_pre",     8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, R_GT);
        a        = 8'h00;
        b        = 8'hFF;
        in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1 check("t5_async_clear", observed(), R_ZERO);
        in_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1 check("t5_no_result_0", observed(), R_ZERO);
        @(posedge clk);
        #1 check("t5_no_result_1", observed(), R_ZERO);
        step("t5_first",   8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, R_LT);

        // T6 random against the reference model
        exp_res = 3'b001;
        for (int i = 0; i < 10000; i++) begin
            ra  = W'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
            req = 1'($urandom);
            rgt = ($urandom_range(0, 3) == 0);
            rv  = (i == 0) || ($urandom_range(0, 3) != 0);
            a        = ra;
            b        = rb;
            eq_in    = req;
            gt_in    = rgt;
            in_valid = rv;
            if (rv) exp_res = ref_cmp(ra, rb, req, rgt);
            exp_ov = rv;
            @(posedge clk);
            #1;
            check("rand", observed(), {exp_ov, exp_res});
            if (out_valid) begin
                check("rand_onehot", {3'b000, $countones({eq_out, gt_out, lt_out}) == 1}, 4'b0001);
            end
        end
        $display("random phase: 10000 cycles");

        in_valid = 1'b0;
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
